// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC sequencer feeding fetched words into an in-order queue drained by decode.
module inst_fetch_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256,
    parameter int QDEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [DATA_W-1:0] read_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              busy,
    output logic [15:0]       fetch_count
);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(MEM_WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [ADDR_W-1:0] q_pc [QDEPTH];
    logic [QW-1:0]     rd_ptr, wr_ptr;
    logic [QW:0]       count;
    logic              empty, full, pop, push;

    assign empty        = count == '0;
    assign full         = count == (QW+1)'(QDEPTH);
    assign pop          = !empty && inst_ready;
    // a full queue can still take a word when the head leaves on the same edge
    assign push         = state == RUN && !redirect && !stop && (!full || pop);
    assign inst_address = pc;
    assign inst_valid   = !empty;
    assign inst_data    = empty ? '0 : q_data[rd_ptr];
    assign inst_pc      = empty ? '0 : q_pc[rd_ptr];
    assign busy         = state == RUN || !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_count <= '0;
        end else if (redirect) begin
            pc     <= redirect_addr & MASK;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (stop)
                state <= IDLE;
        end else begin
            if (stop)
                state <= IDLE;
            else if (start && state == IDLE) begin
                state <= RUN;
                pc    <= start_addr & MASK;
            end
            if (push) begin
                q_data[wr_ptr] <= read_data;
                q_pc[wr_ptr]   <= pc;
                wr_ptr         <= wr_ptr + QW'(1);
                pc             <= (pc + ADDR_W'(1)) & MASK;
                fetch_count    <= fetch_count + 16'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + QW'(1);
            count <= count + (QW+1)'(push) - (QW+1)'(pop);
        end
    end
endmodule
